// File: rtl/led_pkg.sv
// Shared definitions for the LED controller: I2C sequencer states and register map.
package led_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_PTR,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } i2c_ctrl_state_t;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h62;

  // Control byte: bit 7 enables pointer auto-increment, bits 2:0 select the register.
  localparam int AI_BIT = 7;

  localparam logic [2:0] REG_MODE1  = 3'h0;
  localparam logic [2:0] REG_MODE2  = 3'h1;
  localparam logic [2:0] REG_PWM0   = 3'h2;
  localparam logic [2:0] REG_PWM1   = 3'h3;
  localparam logic [2:0] REG_PWM2   = 3'h4;
  localparam logic [2:0] REG_PWM3   = 3'h5;
  localparam logic [2:0] REG_GRPPWM = 3'h6;
  localparam logic [2:0] REG_LEDOUT = 3'h7;

  localparam int SLEEP_BIT = 4;

endpackage

// File: rtl/i2c_reg_ctrl.sv
// I2C transaction sequencer: decodes address/control bytes, keeps the register
// pointer and turns bus events into register write/read strobes.
module i2c_reg_ctrl
  import led_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int         ADDR_W   = 3,
  parameter int         DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i2c_start,
  input  logic              i2c_stop,
  input  logic [DATA_W-1:0] i2c_byte,
  input  logic              i2c_byte_valid,
  output logic              i2c_ack,
  input  logic              tx_req,
  output logic [DATA_W-1:0] tx_byte,
  output logic              tx_valid,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_write,
  output logic              reg_read,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  i2c_ctrl_state_t   state;
  logic [ADDR_W-1:0] ptr;
  logic              ai;
  logic              wr_vld_p0;
  logic              rd_vld_p0;
  logic              dmy_vld_p0;
  logic              tx_vld_p1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      ai         <= 1'b0;
      i2c_ack    <= 1'b0;
      tx_byte    <= '1;
      tx_vld_p1  <= 1'b0;
      wr_vld_p0  <= 1'b0;
      rd_vld_p0  <= 1'b0;
      dmy_vld_p0 <= 1'b0;
      reg_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      wr_vld_p0  <= 1'b0;
      rd_vld_p0  <= 1'b0;
      dmy_vld_p0 <= 1'b0;
      tx_vld_p1  <= 1'b0;

      // p0 -> p1: strobe cycle completes; advance pointer and return read data
      if (wr_vld_p0 && ai) ptr <= ptr + ADDR_W'(1);
      if (rd_vld_p0) begin
        tx_byte   <= reg_rdata;
        tx_vld_p1 <= 1'b1;
        if (ai) ptr <= ptr + ADDR_W'(1);
      end
      if (dmy_vld_p0) begin
        tx_byte   <= '1;
        tx_vld_p1 <= 1'b1;
      end

      // event decode -> p0: schedule strobes for the following cycle
      if (tx_req) begin
        if (state == ST_RDATA) rd_vld_p0  <= 1'b1;
        else                   dmy_vld_p0 <= 1'b1;
      end

      if (i2c_stop) begin
        state   <= ST_IDLE;
        busy    <= 1'b0;
        i2c_ack <= 1'b0;
      end else if (i2c_start) begin
        state   <= ST_ADDR;
        i2c_ack <= 1'b0;
      end else if (i2c_byte_valid) begin
        unique case (state)
          ST_IDLE: ;
          ST_ADDR: begin
            if (i2c_byte[7:1] == DEV_ADDR) begin
              i2c_ack <= 1'b1;
              busy    <= 1'b1;
              state   <= i2c_byte[0] ? ST_RDATA : ST_PTR;
            end else begin
              i2c_ack <= 1'b0;
              busy    <= 1'b0;
              state   <= ST_IGNORE;
            end
          end
          ST_PTR: begin
            ptr     <= i2c_byte[ADDR_W-1:0];
            ai      <= i2c_byte[AI_BIT];
            i2c_ack <= 1'b1;
            state   <= ST_WDATA;
          end
          ST_WDATA: begin
            wr_vld_p0 <= 1'b1;
            reg_wdata <= i2c_byte;
            i2c_ack   <= 1'b1;
          end
          ST_RDATA:  i2c_ack <= 1'b0;
          ST_IGNORE: i2c_ack <= 1'b0;
          default:   state   <= ST_IDLE;
        endcase
      end
    end
  end

  // Strobes are masked by reset so a reset landing on a strobe cycle emits nothing.
  assign reg_write = wr_vld_p0 & reset;
  assign reg_read  = rd_vld_p0 & reset;
  assign tx_valid  = tx_vld_p1;
  assign reg_addr  = ptr;

endmodule
